// File: rtl/simon_round_sequencer.sv
// simon_round_sequencer
//
// Runs one full SIMON block operation on the shared single-round unit.
// A block is accepted over io_iValid/io_iReady. Its mode and direction are
// latched, and rounds are issued one at a time. Each round result is fed
// back as the next round input, and the final block is presented on
// io_oValid/io_oReady.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   io_mode               0 = 64/128 (32-bit words), 1 = 128/128 (64-bit words)
//   io_encDec             1 = encrypt, 0 = decrypt
//   io_block1In/2In       input words x / y
//   io_iValid/io_iReady   input handshake
//   io_block1Out/2Out     result words x / y
//   io_oValid/io_oReady   output handshake
//   io_err                sticky abort flag, cleared by the next accept
//   io_expValid           expanded key bank valid
//   io_keyIdx/io_keyData  round-key index into the bank / combinational key word
//   r_*                   connections to the SimonRound datapath
//
// Optional feature macro: SIMON_SEQ_DECRYPT_EN
//   defined   : decrypt runs with the reverse key order and r_encDec = 0
//   undefined : every request runs as encrypt; r_encDec is tied to 1
//
// state | meaning
// IDLE  | waiting for a block; io_iReady follows io_expValid
// ISSUE | one-cycle r_iValid pulse carrying the working words and round key
// WAIT  | waiting for r_oValid from the round unit
// DONE  | result held on io_block*Out until io_oReady
module simon_round_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_mode,
    input  logic        io_encDec,
    input  logic [63:0] io_block1In,
    input  logic [63:0] io_block2In,
    input  logic        io_iValid,
    output logic        io_iReady,
    output logic [63:0] io_block1Out,
    output logic [63:0] io_block2Out,
    output logic        io_oValid,
    input  logic        io_oReady,
    output logic        io_err,
    input  logic        io_expValid,
    output logic [6:0]  io_keyIdx,
    input  logic [63:0] io_keyData,
    output logic [63:0] r_block1,
    output logic [63:0] r_block2,
    output logic [63:0] r_roundKey,
    output logic        r_encDec,
    output logic        r_mode,
    output logic        r_iValid,
    input  logic        r_oValid,
    input  logic [63:0] r_block1Out,
    input  logic [63:0] r_block2Out
);

    localparam logic       MODE_64_128    = 1'b0;
    localparam logic [6:0] ROUNDS_64_128  = 7'd44;
    localparam logic [6:0] ROUNDS_128_128 = 7'd68;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q;
    logic [6:0]  idx_q;
    logic [63:0] blk1_q, blk2_q;
    logic        mode_q;
    logic        err_q;

    logic        accept;
    logic        abort;
    logic        capture;
    logic [6:0]  rounds_sel;
    logic [63:0] in_mask;
    logic [6:0]  idx_start;
    logic [6:0]  idx_next;

    assign accept  = (state_q == IDLE) & io_iValid & io_expValid;
    // Losing the key bank mid-operation invalidates every remaining round key.
    assign abort   = ((state_q == ISSUE) | (state_q == WAIT)) & ~io_expValid;
    assign capture = (state_q == WAIT) & r_oValid & io_expValid;

    assign rounds_sel = (io_mode == MODE_64_128) ? ROUNDS_64_128 : ROUNDS_128_128;
    assign in_mask    = (io_mode == MODE_64_128) ? 64'h0000_0000_ffff_ffff : {64{1'b1}};

`ifdef SIMON_SEQ_DECRYPT_EN
    logic enc_q;

    assign idx_start = io_encDec ? 7'd0 : (rounds_sel - 7'd1);
    assign idx_next  = enc_q ? (idx_q + 7'd1) : (idx_q - 7'd1);
    assign r_encDec  = enc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            enc_q <= 1'b0;
        end else if (accept) begin
            enc_q <= io_encDec;
        end
    end
`else
    logic unused_enc_dec;

    assign unused_enc_dec = io_encDec;
    assign idx_start      = 7'd0;
    assign idx_next       = idx_q + 7'd1;
    assign r_encDec       = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        io_iReady  = 1'b0;
        io_oValid  = 1'b0;
        r_iValid   = 1'b0;
        r_roundKey = '0;
        case (state_q)
            IDLE: begin
                io_iReady = io_expValid;
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // No round is launched with a key from an invalid bank.
                r_iValid   = io_expValid;
                r_roundKey = io_keyData;
                state_d    = abort ? IDLE : WAIT;
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (capture) begin
                    state_d = (cnt_q == 7'd1) ? DONE : ISSUE;
                end
            end
            DONE: begin
                io_oValid = 1'b1;
                if (io_oReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            blk1_q  <= '0;
            blk2_q  <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q <= io_mode;
                blk1_q <= io_block1In & in_mask;
                blk2_q <= io_block2In & in_mask;
                cnt_q  <= rounds_sel;
                idx_q  <= idx_start;
                err_q  <= 1'b0;
            end else if (abort) begin
                err_q <= 1'b1;
            end else if (capture) begin
                blk1_q <= r_block1Out;
                blk2_q <= r_block2Out;
                cnt_q  <= cnt_q - 7'd1;
                idx_q  <= idx_next;
            end
        end
    end

    assign io_block1Out = blk1_q;
    assign io_block2Out = blk2_q;
    assign io_err       = err_q;
    assign io_keyIdx    = idx_q;
    assign r_block1     = blk1_q;
    assign r_block2     = blk2_q;
    assign r_mode       = mode_q;

endmodule
